// File: rtl/board_io_ctrl.sv
// Board-side I/O front end: button synchroniser/debouncer, press-to-FIFO writer
// with a first-word-fall-through valid/ready output, and a scanned hex display.
module board_io_ctrl #(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned SCAN_DIV  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      button,
  input  logic                      sw_valid,
  input  logic [DATA_W-1:0]         sw_data,
  output logic [DATA_W-1:0]         in_data,
  output logic                      in_vld,
  input  logic                      in_rdy,
  output logic [$clog2(DEPTH):0]    cnt,
  output logic                      full,
  output logic                      overflow,
  input  logic [4*DIGITS-1:0]       disp_val,
  output logic [$clog2(DIGITS)-1:0] an,
  output logic [3:0]                seg
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned AN_W  = $clog2(DIGITS);
  localparam int unsigned DBC_W = $clog2(DB_CYCLES + 1);
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // ---------------------------------------------------------------------------
  // Button path state
  // ---------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [DBC_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level flips after DB_CYCLES consecutive disagreeing samples
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DBC_W'(DB_CYCLES - 1)) begin
        db_d     = ~db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DBC_W'(1);
      end
    end
  end

  // Press pulse on the debounced rising edge only
  always_comb begin
    press_d = db_q & ~db_dly_q;
  end

  // Debouncer and press-pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, push_ok;

  // Pointer, occupancy and sticky overflow next-state
  always_comb begin
    push    = press_q & sw_valid;
    pop     = vld_q & in_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok = push & (~full_q | pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | (push & ~push_ok);
    if (push_ok) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    vld_d  = (cnt_d != '0);
    full_d = (cnt_d == CNT_W'(DEPTH));
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= sw_data;
    end
  end

  assign in_data  = mem_q[rptr_q];
  assign in_vld   = vld_q;
  assign cnt      = cnt_q;
  assign full     = full_q;
  assign overflow = ovf_q;

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [AN_W-1:0]  an_q, an_d;

  // Scan divider; digit index advances and wraps at terminal count
  always_comb begin
    div_d = div_q + DIV_W'(1);
    an_d  = an_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      an_d  = an_q + AN_W'(1);
    end
  end

  // Display scan registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
      an_q  <= '0;
    end else begin
      div_q <= div_d;
      an_q  <= an_d;
    end
  end

  assign an  = an_q;
  assign seg = disp_val[{an_q, 2'b00} +: 4];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: directed scenarios plus randomized
// button/handshake traffic, all compared against a behavioural model.
module tb_board_io_ctrl;

  localparam int unsigned DATA_W    = 5;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned DIGITS    = 8;
  localparam int unsigned DB_CYCLES = 4;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam int unsigned AN_W      = $clog2(DIGITS);

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 button = 1'b0;
  logic                 sw_valid = 1'b0;
  logic [DATA_W-1:0]    sw_data = '0;
  logic                 in_rdy = 1'b0;
  logic [4*DIGITS-1:0]  disp_val = '0;
  logic [DATA_W-1:0]    in_data;
  logic                 in_vld;
  logic [CNT_W-1:0]     cnt;
  logic                 full;
  logic                 overflow;
  logic [AN_W-1:0]      an;
  logic [3:0]           seg;

  board_io_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DIGITS(DIGITS),
    .DB_CYCLES(DB_CYCLES), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rstn(rstn), .button(button), .sw_valid(sw_valid),
    .sw_data(sw_data), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .cnt(cnt), .full(full), .overflow(overflow), .disp_val(disp_val),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit               hist[$];   // raw button value seen at each edge since reset
  bit               m_db;      // model debounced level
  bit               m_rise;    // debounced level rose at the latest edge
  bit               m_press;   // press pulse visible in the current cycle
  logic [DATA_W-1:0] mq[$];    // FIFO contents, head first
  bit               m_ovf;
  int               m_ticks;   // clock edges since reset release

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mq.delete();
    m_db    = 1'b0;
    m_rise  = 1'b0;
    m_press = 1'b0;
    m_ovf   = 1'b0;
    m_ticks = 0;
  endtask

  // Advance one clock, update the model from the inputs present at the edge, compare
  task automatic step();
    bit pop, push, all_diff, s;
    int k, idx, exp_an;
    @(posedge clk);
    pop  = (mq.size() != 0) && in_rdy;
    push = m_press && sw_valid;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(sw_data);
      else m_ovf = 1'b1;
    end
    // Level flips when the last DB_CYCLES synchronised samples all disagree with it;
    // the synchroniser delays the raw sample by two edges
    hist.push_back(button);
    k = hist.size() - 1;
    all_diff = 1'b1;
    for (int i = 0; i < DB_CYCLES; i++) begin
      idx = k - 2 - i;
      s = (idx >= 0) ? hist[idx] : 1'b0;
      if (s == m_db) all_diff = 1'b0;
    end
    m_press = m_rise;
    m_rise  = all_diff && !m_db;
    if (all_diff) m_db = !m_db;
    m_ticks++;
    #1;
    exp_an = (m_ticks / SCAN_DIV) % DIGITS;
    check_eq("cnt", 32'(cnt), 32'(mq.size()));
    check_eq("in_vld", 32'(in_vld), 32'(mq.size() != 0));
    if (mq.size() != 0) check_eq("in_data", 32'(in_data), 32'(mq[0]));
    check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(disp_val[4*exp_an +: 4]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_in_vld", 32'(in_vld), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_an", 32'(an), 32'd0);
    check_eq("rst_seg", 32'(seg), 32'(disp_val[3:0]));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Clean press: hold for 'hold' cycles then release long enough to settle
  task automatic press(input logic [DATA_W-1:0] d, input bit v, input int hold);
    sw_data  = d;
    sw_valid = v;
    button   = 1'b1;
    steps(hold);
    button = 1'b0;
    steps(DB_CYCLES + 6);
  endtask

  initial begin
    int prev_an;
    int len;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    steps(2);

    // Bounce shorter than the debounce window never reaches the FIFO
    sw_valid = 1'b1;
    sw_data  = 5'h1f;
    for (int i = 0; i < 6; i++) begin
      button = (i % 2 == 0);
      step();
      check_eq("bounce_cnt", 32'(cnt), 32'd0);
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bounce_cnt", 32'(cnt), 32'd0);
    end

    // Clean press: word visible exactly 7 clocks after the first high sample
    in_rdy  = 1'b0;
    sw_data = 5'h01;
    button  = 1'b1;
    steps(7);
    check_eq("lat_vld_early", 32'(in_vld), 32'd0);
    step();
    check_eq("lat_vld", 32'(in_vld), 32'd1);
    check_eq("lat_data", 32'(in_data), 32'h01);
    steps(12);
    button = 1'b0;
    steps(10);
    check_eq("press_cnt", 32'(cnt), 32'd1);

    // Press with switch word disabled is ignored
    press(5'h02, 1'b0, 12);
    check_eq("novalid_cnt", 32'(cnt), 32'd1);
    check_eq("novalid_data", 32'(in_data), 32'h01);

    // Fill to three entries, then reset mid-run
    press(5'h06, 1'b1, 8);
    press(5'h07, 1'b1, 8);
    check_eq("pre_rst_cnt", 32'(cnt), 32'd3);
    do_reset();
    steps(2);

    // Overflow: five pushes into a four-deep FIFO, then drain
    for (int i = 1; i <= 5; i++) press(DATA_W'(i), 1'b1, 8);
    check_eq("ovf_cnt", 32'(cnt), 32'd4);
    check_eq("ovf_full", 32'(full), 32'd1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("drain_head", 32'(in_data), 32'd1);
    in_rdy = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      check_eq("drain_data", 32'(in_data), 32'(i));
    end
    step();
    check_eq("drain_vld", 32'(in_vld), 32'd0);
    check_eq("drain_cnt", 32'(cnt), 32'd0);
    check_eq("drain_ovf", 32'(overflow), 32'd1);
    in_rdy = 1'b0;

    // Display scan: seg tracks the digit index and the index wraps to 0
    disp_val = 32'h76543210;
    prev_an = int'(an);
    for (int i = 0; i < 4 * SCAN_DIV * DIGITS / 2; i++) begin
      step();
      check_eq("scan_seg", 32'(seg), 32'(an));
      if (prev_an == DIGITS - 1 && int'(an) != prev_an) check_eq("scan_wrap", 32'(an), 32'd0);
      prev_an = int'(an);
    end

    // Randomized traffic: button runs of random length, random handshake and data
    for (int r = 0; r < 400; r++) begin
      button = 1'($urandom_range(0, 1));
      len    = (($urandom_range(0, 3)) == 0) ? $urandom_range(1, DB_CYCLES) : $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        sw_valid = ($urandom_range(0, 7) != 0);
        sw_data  = DATA_W'($urandom);
        in_rdy   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 63) == 0) disp_val = $urandom;
        step();
      end
      if (r == 200) begin
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
